counter_seq_ctrl: RTL
=====================

Name: counter_seq_ctrl

Overview:
- Controller that sequences the 8-bit free-running counter datapath and turns it into a programmable timer.
- Accepts commands over a valid/ready interface and drives the counter's clear/increment strobes through a prescaler.
- Compares the counter value against a programmable top value and raises terminal-count pulses and a sticky interrupt.
- Sits between the pin-level command decode (ui_in/uio_in) and the counter datapath.

Parameters:
- PRESC_W, 4, width of the prescaler counter and of cfg_presc.
- CNT_W, 8, counter width; every top/compare value uses this width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command this cycle
- cmd_op  input  3  opcode (see Behaviour)
- cmd_data  input  CNT_W  operand for SET_TOP and SET_PRESC (low PRESC_W bits)
- cnt_q  input  CNT_W  current counter value from the datapath
- cnt_clr  output  1  synchronous clear strobe to the datapath; counter reads 0 the following cycle
- cnt_inc  output  1  increment strobe; counter reads +1 (mod 2^CNT_W) the following cycle
- running  output  1  high in ARM and RUN
- tc_pulse  output  1  one-cycle terminal-count event
- irq  output  1  sticky interrupt, set by tc_pulse

Behaviour:
- Reset values, applied asynchronously on rst_n low: state=IDLE, top=8'hFF, presc_div=0, presc_cnt=0, mode=0. All outputs low except cmd_ready=1.
- Opcodes:
  - 0 NOP
  - 1 SET_TOP: top<=cmd_data
  - 2 SET_PRESC: presc_div<=cmd_data[PRESC_W-1:0]
  - 3 START_ONESHOT
  - 4 START_PERIODIC
  - 5 STOP
  - 6 CLR_IRQ
  - 7 reserved; accepted and ignored
- Handshake:
  - A command is accepted when cmd_valid & cmd_ready at a clk edge.
  - cmd_ready=0 only in state ARM.
  - Each accepted command takes effect exactly once.
  - SET_TOP and SET_PRESC take effect from the next cycle, including while in RUN.
- States:
  - IDLE: cnt_clr=cnt_inc=0. START_* -> ARM and latches mode (0=oneshot, 1=periodic). STOP -> stays IDLE.
  - ARM (exactly 1 cycle): cnt_clr=1, presc_cnt<=0 -> RUN.
  - RUN: presc_cnt counts 0..presc_div. A tick fires in the cycle presc_cnt==presc_div, and presc_cnt then returns to 0. presc_div=0 gives a tick every cycle.
    - Tick with cnt_q!=top: cnt_inc=1.
    - Tick with cnt_q==top (terminal): tc_pulse=1.
      - periodic: cnt_clr=1 (not cnt_inc), stay in RUN.
      - oneshot: neither strobe, -> DONE.
    - STOP accepted -> IDLE; counter holds its value.
    - START_* accepted -> ARM (restart with the new mode).
  - DONE: counter frozen at top, strobes low, running=0.
    - START_* -> ARM.
    - STOP -> IDLE.
- Latency: START accepted at edge N -> cnt_clr high in cycle N+1 -> cnt_q=0 and RUN at N+2. The first tick is presc_div+1 cycles after entering RUN.
- Priority: a command accepted in the same cycle as a terminal tick wins over that tick. STOP/START suppress tc_pulse, the strobes and the irq set for that cycle.
- top=0: every tick is terminal. Periodic gives tc_pulse on every tick; oneshot finishes on the first tick.
- top lowered below cnt_q mid-run: no match until the counter wraps 255->0 via cnt_inc, then counts up to top. This wrap is defined behaviour.
- irq: set on tc_pulse, cleared by CLR_IRQ. A simultaneous set and clear leaves irq set.
- cnt_clr and cnt_inc are never high in the same cycle.
- rst_n low mid-RUN: immediate return to the reset values; no tc_pulse is emitted.

Decomposition:
- Shared package counter_pkg:
  - opcode enum cmd_op_e (OP_NOP..OP_RSVD)
  - state enum seq_state_e (IDLE, ARM, RUN, DONE)
  - CNT_W default constant
- One natural sub-module: presc_tick (PRESC_W counter with clear input, div input and tick output).
- The counter datapath stays a separate existing block; this controller only drives its strobes.

Test Plan:
- Reset defaults: hold rst_n=0 -> cmd_ready=1, running=0, irq=0, cnt_clr=cnt_inc=0. Release, then run START_PERIODIC with no SET_TOP -> top=255, so tc_pulse after 256 ticks.
- Oneshot: SET_TOP 3, SET_PRESC 0, START_ONESHOT -> cnt_clr one cycle, then cnt_q 0,1,2,3. tc_pulse exactly once when cnt_q==3, then DONE, irq=1, cnt_q stays 3, running=0.
- Periodic with prescaler: SET_TOP 2, SET_PRESC 1 -> tc_pulse every 6 cycles. Sequence is 0,0,1,1,2,2, then clear. cnt_inc never asserted at cnt_q==2. Run 3 periods.
- Collision: in periodic, issue STOP in the terminal-tick cycle -> no tc_pulse, irq unchanged, state IDLE, cnt_q holds 2. CLR_IRQ concurrent with a tc_pulse -> irq remains 1.
- Edge values:
  - top=0 periodic -> tc_pulse on every tick.
  - SET_TOP 1 while cnt_q=5 -> counter wraps 255->0->1, then tc_pulse.
  - cmd_ready=0 during ARM, with a held cmd_valid accepted the next cycle.
- Async reset mid-RUN: assert rst_n=0 between clk edges -> outputs return to the reset values immediately. After release, no command is executed twice.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sequencing controller.
// Opcode and state encodings live here so decode and datapath glue agree.
package counter_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_NOP            = 3'd0,
    OP_SET_TOP        = 3'd1,
    OP_SET_PRESC      = 3'd2,
    OP_START_ONESHOT  = 3'd3,
    OP_START_PERIODIC = 3'd4,
    OP_STOP           = 3'd5,
    OP_CLR_IRQ        = 3'd6,
    OP_RSVD           = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  function automatic logic is_start(cmd_op_e op);
    return (op == OP_START_ONESHOT) || (op == OP_START_PERIODIC);
  endfunction

endpackage

// File: rtl/presc_tick.sv
// Prescaler: counts 0..i_div while enabled and fires o_tick on the last count.
// A div of zero therefore ticks every enabled cycle.
module presc_tick #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_div,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Timer controller: accepts commands, sequences the external counter through
// a prescaler and raises terminal-count pulses plus a sticky interrupt.
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_clr,
  output logic             cnt_inc,
  output logic             running,
  output logic             tc_pulse,
  output logic             irq
);

  seq_state_e         r_state;
  seq_state_e         w_next;
  logic [CNT_W-1:0]   r_top;
  logic [PRESC_W-1:0] r_presc_div;
  logic               r_mode;
  logic               r_irq;

  cmd_op_e            w_op;
  logic               w_accept;
  logic               w_start;
  logic               w_stop;
  logic               w_tick;
  logic               w_presc_clr;
  logic               w_presc_en;

  assign w_op        = cmd_op_e'(cmd_op);
  assign cmd_ready   = (r_state != ARM);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_start     = w_accept && is_start(w_op);
  assign w_stop      = w_accept && (w_op == OP_STOP);
  assign w_presc_clr = (r_state == ARM);
  assign w_presc_en  = (r_state == RUN);
  assign running     = (r_state == ARM) || (r_state == RUN);
  assign irq         = r_irq;

  presc_tick #(
    .PRESC_W(PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_presc_clr),
    .i_en   (w_presc_en),
    .i_div  (r_presc_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An accepted START/STOP in RUN pre-empts whatever the tick would have done.
  always_comb begin
    w_next   = r_state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    tc_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_next = ARM;
      end
      ARM: begin
        cnt_clr = 1'b1;
        w_next  = RUN;
      end
      RUN: begin
        if (w_start) begin
          w_next = ARM;
        end else if (w_stop) begin
          w_next = IDLE;
        end else if (w_tick) begin
          if (cnt_q == r_top) begin
            tc_pulse = 1'b1;
            if (r_mode) begin
              cnt_clr = 1'b1;
            end else begin
              w_next = DONE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DONE: begin
        if (w_start) begin
          w_next = ARM;
        end else if (w_stop) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A terminal pulse outranks CLR_IRQ arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top       <= '1;
      r_presc_div <= '0;
      r_mode      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (tc_pulse) begin
        r_irq <= 1'b1;
      end else if (w_accept && (w_op == OP_CLR_IRQ)) begin
        r_irq <= 1'b0;
      end
      if (w_accept) begin
        case (w_op)
          OP_SET_TOP:        r_top       <= cmd_data;
          OP_SET_PRESC:      r_presc_div <= cmd_data[PRESC_W-1:0];
          OP_START_ONESHOT:  r_mode      <= 1'b0;
          OP_START_PERIODIC: r_mode      <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
